// File: rtl/alu_host.sv
// Host-side sequencer for the serial ALU: loads op/a/b over BEGIN/inbus, waits for END
// under a watchdog, and returns the one- or two-byte result on a valid/ready port.
module alu_host #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        BEGIN,
  output logic [1:0]  op_code,
  output logic [7:0]  inbus,
  input  logic [7:0]  outbus,
  input  logic        END
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_HIGH,
    S_RESP
  } state_t;

  state_t        state, state_next;
  logic [7:0]    a_r, b_r, a_next, b_next;
  logic [1:0]    op_next;
  logic [CW-1:0] wdog, wdog_next;
  logic          begin_next, rsp_valid_next, rsp_err_next;
  logic [7:0]    inbus_next;
  logic [15:0]   rsp_data_next;
  logic          timed_out;

  assign timed_out = (wdog == CW'(TIMEOUT - 1));
  assign req_ready = (state == S_IDLE);

  // Every ALU-facing and response output is a flop loaded from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      op_code   <= 2'b00;
      wdog      <= '0;
      BEGIN     <= 1'b0;
      inbus     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 16'h0000;
    end else begin
      state     <= state_next;
      a_r       <= a_next;
      b_r       <= b_next;
      op_code   <= op_next;
      wdog      <= wdog_next;
      BEGIN     <= begin_next;
      inbus     <= inbus_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_data  <= rsp_data_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_valid) state_next = S_START;
      S_START:  state_next = S_LOAD_A;
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_WAIT;
      S_WAIT: begin
        if (END)            state_next = op_code[1] ? S_HIGH : S_RESP;
        else if (timed_out) state_next = S_RESP;
      end
      S_HIGH:   state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // END beats the watchdog when both land on the same WAIT cycle.
  always_comb begin
    a_next         = a_r;
    b_next         = b_r;
    op_next        = op_code;
    wdog_next      = wdog;
    begin_next     = 1'b0;
    inbus_next     = 8'h00;
    rsp_valid_next = (state_next == S_RESP);
    rsp_err_next   = rsp_err;
    rsp_data_next  = rsp_data;

    if (state == S_IDLE && req_valid) begin
      a_next  = req_a;
      b_next  = req_b;
      op_next = req_op;
    end

    case (state_next)
      S_START:  begin_next = 1'b1;
      S_LOAD_A: begin
        begin_next = 1'b1;
        inbus_next = a_r;
      end
      S_LOAD_B, S_WAIT, S_HIGH, S_RESP: inbus_next = b_r;
      default:  inbus_next = 8'h00;
    endcase

    case (state)
      S_LOAD_B: wdog_next = '0;
      S_WAIT: begin
        if (END) begin
          rsp_data_next = {8'h00, outbus};
        end else if (timed_out) begin
          rsp_data_next = 16'h0000;
          rsp_err_next  = 1'b1;
        end else begin
          wdog_next = wdog + 1'b1;
        end
      end
      S_HIGH:   rsp_data_next[15:8] = outbus;
      S_RESP:   if (rsp_ready) rsp_err_next = 1'b0;
      default:  ;
    endcase
  end

endmodule
